// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer: reads the DIM x DIM result matrix out of a
// synchronous-read RAM (1-cycle latency) and emits it as a valid/ready
// stream tagged with row/column/last, in row- or column-major order.
// A 2-entry skid FIFO hides the RAM latency under backpressure.
module matrix_result_streamer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DIM    = 4,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              col_major,
  output logic              busy,
  output logic              done,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        m_row,
  output logic [1:0]        m_col,
  output logic              m_last
);

  localparam int unsigned N     = DIM * DIM;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] DIM_C  = CNT_W'(DIM);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic               colmaj_q;
  logic [CNT_W-1:0]   issue_q;
  logic [CNT_W-1:0]   emit_q;
  logic               inflight_q;
  logic [3:0]         tag_q;
  logic [DATA_W-1:0]  fifo_data_q [2];
  logic [3:0]         fifo_tag_q  [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         count_q;
  logic               done_q;

  logic               start_acc;
  logic               pop;
  logic               last_pop;
  logic               room;
  logic [2:0]         occ;
  logic [CNT_W-1:0]   k_div, k_mod;
  logic [CNT_W-1:0]   r_idx, c_idx;
  logic [ADDR_W-1:0]  addr;

  // Handshake, issue-index decode and FIFO occupancy headroom
  always_comb begin
    start_acc = (state_q == S_IDLE) && start;
    m_valid   = (count_q != 2'd0);
    pop       = m_valid && m_ready;
    last_pop  = pop && (emit_q == LAST_C);
    k_div     = issue_q / DIM_C;
    k_mod     = issue_q % DIM_C;
    r_idx     = colmaj_q ? k_mod : k_div;
    c_idx     = colmaj_q ? k_div : k_mod;
    addr      = ADDR_W'(r_idx * DIM_C + c_idx);
    // Entries held plus the read in flight, minus the one leaving this cycle,
    // must stay below the FIFO depth; pop is added on the right to avoid underflow.
    occ       = 3'(count_q) + 3'(inflight_q);
    room      = occ < (3'd2 + 3'(pop));
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_acc) state_d = S_RUN;
      S_RUN:   if (mem_ren && (issue_q == LAST_C)) state_d = S_DRAIN;
      S_DRAIN: if (last_pop) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: busy, read strobe and address
  always_comb begin
    busy     = (state_q != S_IDLE);
    mem_ren  = (state_q == S_RUN) && room;
    mem_addr = mem_ren ? addr : '0;
  end

  // Counters, in-flight tracking, skid FIFO and done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      colmaj_q   <= 1'b0;
      issue_q    <= '0;
      emit_q     <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
      done_q     <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_tag_q[i]  <= '0;
      end
    end else begin
      inflight_q <= mem_ren;
      if (mem_ren) tag_q <= {2'(r_idx), 2'(c_idx)};

      if (start_acc) begin
        colmaj_q <= col_major;
        issue_q  <= '0;
        emit_q   <= '0;
      end else begin
        if (mem_ren) issue_q <= issue_q + 1'b1;
        if (pop && (emit_q != LAST_C)) emit_q <= emit_q + 1'b1;
      end

      if (inflight_q) begin
        fifo_data_q[wr_ptr_q] <= mem_dout;
        fifo_tag_q[wr_ptr_q]  <= tag_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(inflight_q) - 2'(pop);

      done_q <= (state_q == S_DRAIN) && last_pop;
    end
  end

  // Stream outputs taken from the registered FIFO head
  always_comb begin
    m_data = fifo_data_q[rd_ptr_q];
    m_row  = fifo_tag_q[rd_ptr_q][3:2];
    m_col  = fifo_tag_q[rd_ptr_q][1:0];
    m_last = m_valid && (emit_q == LAST_C);
    done   = done_q;
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Self-checking bench for matrix_result_streamer: a RAM model feeds the DUT,
// a reference queue of expected beats is built directly from the ordering
// rules, and every accepted beat, read address and stall is checked.
module tb_matrix_result_streamer;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DIM    = 4;
  localparam int unsigned ADDR_W = 4;
  localparam int          N      = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              col_major;
  logic              busy, done, mem_ren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic              m_valid, m_ready;
  logic [DATA_W-1:0] m_data;
  logic [1:0]        m_row, m_col;
  logic              m_last;

  matrix_result_streamer #(.DATA_W(DATA_W), .DIM(DIM), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .col_major(col_major),
    .busy(busy), .done(done), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_row(m_row), .m_col(m_col), .m_last(m_last)
  );

  always #5 clk = ~clk;

  // Result RAM model: synchronous read, one cycle latency
  logic [DATA_W-1:0] ram [N];
  always @(posedge clk) if (mem_ren) mem_dout <= ram[mem_addr];

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [1:0]        row;
    logic [1:0]        col;
    logic              last;
  } beat_t;

  beat_t expq[$];
  int    addrq[$];

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int start_at = -1000, start_ign = -1000, start_at2 = -1000;
  logic pass_cm = 1'b0;
  int ready_mode = 0, ready_pct = 100, release_rel = 0;
  int reads = 0, beats = 0, dones = 0;
  int reads_base = 0, beats_base = 0, dones_base = 0;
  int first_ren_rel = -1, first_valid_rel = -1, first_done_rel = -1, done_rel = -1;
  logic prev_stall = 1'b0;
  logic [DATA_W-1:0] p_data;
  logic [1:0] p_row, p_col;
  logic p_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected beats for one pass, straight from the ordering rules
  task automatic plan_pass(input logic cm);
    for (int k = 0; k < N; k++) begin
      beat_t e;
      int r, c;
      r = cm ? (k % DIM) : (k / DIM);
      c = cm ? (k / DIM) : (k % DIM);
      e.data = ram[r*DIM + c];
      e.row  = 2'(r);
      e.col  = 2'(c);
      e.last = (k == N-1);
      expq.push_back(e);
      addrq.push_back(r*DIM + c);
    end
  endtask

  task automatic monitor();
    int rel;
    rel = cyc - start_at;
    if (rel == 1) chk("busy_after_start", 32'(busy), 1);
    if (mem_ren) begin
      reads++;
      if (first_ren_rel < 0) first_ren_rel = rel;
      if (addrq.size() == 0) chk("extra_read", 1, 0);
      else chk("mem_addr", 32'(mem_addr), addrq.pop_front());
    end
    if (m_valid && first_valid_rel < 0) first_valid_rel = rel;
    if (prev_stall) begin
      chk("stall_valid", 32'(m_valid), 1);
      chk("stall_data", 32'(m_data), 32'(p_data));
      chk("stall_row", 32'(m_row), 32'(p_row));
      chk("stall_col", 32'(m_col), 32'(p_col));
      chk("stall_last", 32'(m_last), 32'(p_last));
    end
    if (m_valid && m_ready) begin
      beats++;
      if (expq.size() == 0) chk("extra_beat", 1, 0);
      else begin
        beat_t e;
        e = expq.pop_front();
        chk("beat_data", 32'(m_data), 32'(e.data));
        chk("beat_row", 32'(m_row), 32'(e.row));
        chk("beat_col", 32'(m_col), 32'(e.col));
        chk("beat_last", 32'(m_last), 32'(e.last));
      end
    end
    chk("occupancy_le_2", 32'((reads - beats) <= 2), 1);
    if (done) begin
      dones++;
      if (first_done_rel < 0) first_done_rel = rel;
      done_rel = rel;
      chk("busy_low_at_done", 32'(busy), 0);
    end
    prev_stall = m_valid && !m_ready;
    p_data = m_data; p_row = m_row; p_col = m_col; p_last = m_last;
  endtask

  task automatic tick();
    int rel;
    @(posedge clk); #1;
    cyc++;
    rel = cyc - start_at;
    start = (cyc == start_at) || (cyc == start_ign) || (cyc == start_at2);
    col_major = start ? pass_cm : 1'($urandom);
    case (ready_mode)
      0: m_ready = 1'b1;
      1: m_ready = ((rel % 4) == 0) || ((rel % 4) == 3);
      2: m_ready = ($urandom_range(99) < ready_pct);
      default: m_ready = (rel >= release_rel);
    endcase
    @(negedge clk);
    monitor();
  endtask

  task automatic begin_pass(input logic cm, input int mode);
    pass_cm = cm;
    ready_mode = mode;
    plan_pass(cm);
    start_at = cyc + 1;
    reads_base = reads; beats_base = beats; dones_base = dones;
    first_ren_rel = -1; first_valid_rel = -1; first_done_rel = -1; done_rel = -1;
  endtask

  task automatic wait_done(input int ndone, input int budget);
    int n = 0;
    while ((dones - dones_base) < ndone && n < budget) begin
      tick();
      n++;
    end
    if ((dones - dones_base) < ndone) chk("done_timeout", 0, 1);
  endtask

  task automatic end_pass(input int npass);
    repeat (4) tick();
    chk("beats_pending", 32'(expq.size()), 0);
    chk("reads_pending", 32'(addrq.size()), 0);
    chk("beat_count", 32'(beats - beats_base), 32'(N*npass));
    chk("read_count", 32'(reads - reads_base), 32'(N*npass));
    chk("done_count", 32'(dones - dones_base), 32'(npass));
    expq.delete();
    addrq.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_mem_ren"}, 32'(mem_ren), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_m_valid"}, 32'(m_valid), 0);
    chk({tag, "_m_data"}, 32'(m_data), 0);
    chk({tag, "_m_row"}, 32'(m_row), 0);
    chk({tag, "_m_col"}, 32'(m_col), 0);
    chk({tag, "_m_last"}, 32'(m_last), 0);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < N; i++) ram[i] = 16'(i * 16'h0101);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) ram[i] = 16'($urandom);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; col_major = 1'b0; m_ready = 1'b0;
    fill_ramp();
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) tick();

    // Row-major, full throughput, exact latency
    begin_pass(1'b0, 0);
    wait_done(1, 60);
    chk("rm_first_ren_cycle", 32'(first_ren_rel), 1);
    chk("rm_first_valid_cycle", 32'(first_valid_rel), 3);
    chk("rm_done_cycle", 32'(first_done_rel), 19);
    end_pass(1);

    // Column-major, full throughput
    begin_pass(1'b1, 0);
    wait_done(1, 60);
    chk("cm_first_valid_cycle", 32'(first_valid_rel), 3);
    chk("cm_done_cycle", 32'(first_done_rel), 19);
    end_pass(1);

    // Ready pattern 1,0,0,1 with random contents
    fill_random();
    begin_pass(1'($urandom), 1);
    wait_done(1, 200);
    end_pass(1);

    // Ready held low for 20 cycles after start
    fill_ramp();
    release_rel = 21;
    begin_pass(1'b0, 3);
    while ((cyc - start_at) < 20) tick();
    chk("hold_reads", 32'(reads - reads_base), 2);
    chk("hold_valid", 32'(m_valid), 1);
    chk("hold_data", 32'(m_data), 32'(ram[0]));
    wait_done(1, 100);
    end_pass(1);

    // Start during a run is ignored; start in the done cycle is accepted
    fill_random();
    begin_pass(1'b0, 0);
    start_ign = start_at + 5;
    start_at2 = start_at + 19;
    plan_pass(1'b0);
    wait_done(2, 120);
    chk("restart_first_done", 32'(first_done_rel), 19);
    chk("restart_second_done", 32'(done_rel), 38);
    end_pass(2);
    start_ign = -1000;
    start_at2 = -1000;

    // Asynchronous reset mid-stream, then a clean pass
    fill_ramp();
    begin_pass(1'b0, 0);
    while ((cyc - start_at) < 7) tick();
    @(posedge clk); #1;
    cyc++;
    start = 1'b0;
    reset = 1'b0;
    #1 check_zero("midreset");
    expq.delete();
    addrq.delete();
    reads = 0; beats = 0; prev_stall = 1'b0;
    dones_base = dones;
    repeat (3) tick();
    reset = 1'b1;
    repeat (4) tick();
    chk("no_done_after_reset", 32'(dones - dones_base), 0);
    check_zero("after_reset_idle");
    begin_pass(1'b0, 2);
    ready_pct = 60;
    wait_done(1, 200);
    end_pass(1);

    // Randomised passes
    for (int p = 0; p < 6; p++) begin
      fill_random();
      ready_pct = $urandom_range(100, 20);
      begin_pass(1'($urandom), 2);
      wait_done(1, 500);
      end_pass(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_result_streamer.md
Name: matrix_result_streamer

Overview:
- Downstream stage of the 4x4 fixed-point matrix multiplier.
- Reads the DIM×DIM result matrix out of the multiplier's result RAM, which has a synchronous read port with 1-cycle latency.
- Emits the elements as a valid/ready stream tagged with row, column and last-beat flags, in row-major or column-major (transposed) order.
- A 2-entry skid FIFO absorbs RAM read latency under backpressure without losing throughput.

Parameters:
- DATA_W, 16, element width (Q8.8 fixed point, passed through unmodified)
- DIM, 4, matrix dimension; total elements N = DIM*DIM
- ADDR_W, 4, result RAM address width; must satisfy 2**ADDR_W >= N

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  one-cycle request to stream the matrix; ignored while busy=1
- col_major  in  1  sampled only on an accepted start; 1 = emit column-major order
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last beat is accepted
- mem_ren  out  1  read enable to result RAM
- mem_addr  out  ADDR_W  read address, always r*DIM+c
- mem_dout  in  DATA_W  RAM read data, valid the cycle after mem_ren
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_W  element value
- m_row  out  2  row index of element
- m_col  out  2  column index of element
- m_last  out  1  high on the final (N-th) beat

Behaviour:
- Reset (reset=0, asynchronous): FSM→IDLE. All counters, FIFO pointers and the in-flight flag clear. All outputs go to 0, including busy, done, mem_ren, mem_addr, m_valid, m_data, m_row, m_col and m_last.
- Reset mid-stream: in-flight read data is discarded and no done pulse is produced.
- FSM states and transitions:
  - IDLE→RUN on start=1. Latch col_major and clear the issue and emit counters.
  - RUN→DRAIN when all N reads are issued.
  - DRAIN→IDLE when the N-th beat handshakes (m_valid & m_ready). done=1 in the following cycle; busy=0 from that same cycle.
- Issue order: issue index k runs 0..N-1.
  - Row-major: r=k/DIM, c=k%DIM.
  - Column-major: c=k/DIM, r=k%DIM.
  - mem_addr = r*DIM+c. The {r,c} tag travels with the read into the FIFO.
- Read issue rule: in RUN, mem_ren=1 iff (fifo_count + inflight − pop) < 2, where pop = m_valid & m_ready in the same cycle.
  - inflight is 1 if mem_ren was high in the previous cycle.
  - This rule prevents overflow and sustains 1 beat/cycle when m_ready is held high.
- FIFO capture: mem_dout plus the delayed tag are written to the FIFO in the cycle after mem_ren. Push and pop in the same cycle are legal.
- Output:
  - m_valid = FIFO non-empty. m_data, m_row and m_col come from the FIFO head (registered).
  - m_last=1 only on the beat whose emit counter equals N-1.
  - While m_valid=1 and m_ready=0, m_data, m_row, m_col and m_last must hold stable.
- Latency: with start in cycle 0, mem_ren=1 with mem_addr=0 in cycle 1, and m_valid=1 with element 0 in cycle 3.
  - With m_ready held at 1, the last beat is in cycle 3+N-1 = 18, done in cycle 19.
- Boundaries:
  - start while busy: ignored, no restart.
  - start in the same cycle as done: accepted.
  - m_ready may be high while m_valid=0; this has no effect.
  - Counters never wrap past N-1; no reads are issued after the N-th.
  - The FIFO never holds more than 2 entries.
- Data is passed bit-exact; no saturation or arithmetic.

Test Plan:
- RAM preloaded with addr×0x0101 (addr 0..15), col_major=0, m_ready=1, start in cycle 0 -> m_valid first high in cycle 3 with data 0x0000, tag (0,0). One beat per cycle in order 0x0000..0x0F0F. m_last only on 0x0F0F with tag (3,3). done in cycle 19.
- Same preload, col_major=1 -> beat order addr 0,4,8,12,1,5,… Second beat is 0x0404 with tag (1,0). Last beat is 0x0F0F (3,3) with m_last=1.
- m_ready pattern 1,0,0,1 repeating -> all 16 values delivered once, in order, with no loss or duplication. Outputs are stable during stalls. mem_ren never drives FIFO occupancy above 2.
- m_ready=0 for 20 cycles after start -> exactly 2 reads issued, m_valid held with element 0. Releasing m_ready completes the remaining 14 beats normally.
- start pulsed again in cycle 5 of a run -> ignored; exactly 16 beats and one done pulse. A start in the done cycle launches a second full pass.
- reset driven to 0 in cycle 8 mid-stream -> all outputs 0 immediately. No done pulse. A subsequent start streams all 16 elements from element 0.
